// File: rtl/arbiter_vc.sv
// Two-VC to two-destination arbiter with weighted VC0 priority.
// Each transfer runs IDLE grant -> POP -> PUSH.
module arbiter_vc #(
  parameter int DATA_WIDTH = 6,
  parameter int DEST_BIT   = 4,
  parameter int VC0_WEIGHT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  vc0_empty,
  input  logic                  vc1_empty,
  input  logic [DATA_WIDTH-1:0] vc0_head,
  input  logic [DATA_WIDTH-1:0] vc1_head,
  input  logic [DATA_WIDTH-1:0] vc0_data,
  input  logic [DATA_WIDTH-1:0] vc1_data,
  input  logic                  d0_almost_full,
  input  logic                  d1_almost_full,
  output logic                  vc0_pop,
  output logic                  vc1_pop,
  output logic                  d0_push,
  output logic                  d1_push,
  output logic [DATA_WIDTH-1:0] d0_data,
  output logic [DATA_WIDTH-1:0] d1_data,
  output logic                  arb_idle
);

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    POP,
    PUSH
  } state_t;

  localparam logic [2:0] WMAX = 3'(VC0_WEIGHT);

  state_t state, state_nxt;
  logic sel_q, sel_nxt;
  logic dest_q, dest_nxt;
  logic [2:0] fair_cnt, fair_nxt;
  logic run;
  logic elig0, elig1, win1;
  logic [DATA_WIDTH-1:0] word;

  assign run = reset & init;

  assign elig0 = !vc0_empty &&
    !(vc0_head[DEST_BIT] ? d1_almost_full : d0_almost_full);
  assign elig1 = !vc1_empty &&
    !(vc1_head[DEST_BIT] ? d1_almost_full : d0_almost_full);
  // VC1 takes the slot when VC0 is absent or has used its weight
  assign win1 = elig1 && (!elig0 || fair_cnt == WMAX);

  always_ff @(posedge clk) begin
    if (!run) begin
      state    <= INIT;
      sel_q    <= 1'b0;
      dest_q   <= 1'b0;
      fair_cnt <= '0;
    end else begin
      state    <= state_nxt;
      sel_q    <= sel_nxt;
      dest_q   <= dest_nxt;
      fair_cnt <= fair_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_q;
    dest_nxt  = dest_q;
    fair_nxt  = fair_cnt;
    unique case (state)
      INIT: state_nxt = IDLE;
      IDLE: begin
        if (win1) begin
          state_nxt = POP;
          sel_nxt   = 1'b1;
          dest_nxt  = vc1_head[DEST_BIT];
          fair_nxt  = '0;
        end else if (elig0) begin
          state_nxt = POP;
          sel_nxt   = 1'b0;
          dest_nxt  = vc0_head[DEST_BIT];
          if (elig1 && fair_cnt < WMAX)
            fair_nxt = fair_cnt + 3'd1;
        end
      end
      POP:  state_nxt = PUSH;
      PUSH: state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  assign word = sel_q ? vc1_data : vc0_data;

  always_comb begin
    vc0_pop  = (state == POP) && !sel_q;
    vc1_pop  = (state == POP) && sel_q;
    d0_push  = (state == PUSH) && !dest_q;
    d1_push  = (state == PUSH) && dest_q;
    d0_data  = d0_push ? word : '0;
    d1_data  = d1_push ? word : '0;
    arb_idle = (state == IDLE) && vc0_empty && vc1_empty;
  end

endmodule

// File: tb/tb_arbiter_vc.sv
// Bench for arbiter_vc: transfer-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_arbiter_vc;

  localparam int W  = 6;
  localparam int DB = 4;
  localparam int WT = 4;

  logic clk = 1'b0;
  logic reset, init;
  logic vc0_empty, vc1_empty;
  logic [W-1:0] vc0_head, vc1_head, vc0_data, vc1_data;
  logic d0_almost_full, d1_almost_full;
  logic vc0_pop, vc1_pop, d0_push, d1_push;
  logic [W-1:0] d0_data, d1_data;
  logic arb_idle;

  int total = 0;
  int bad = 0;
  int xfers = 0;
  int grant_log[$];

  // model: a transfer is "age" 1 in its pop cycle, 2 in its push cycle
  bit m_init = 1'b1;
  int m_age = 0;
  bit m_win = 1'b0;
  bit m_dst = 1'b0;
  int m_fc = 0;

  arbiter_vc #(.DATA_WIDTH(W), .DEST_BIT(DB), .VC0_WEIGHT(WT)) dut (
    .clk(clk),
    .reset(reset),
    .init(init),
    .vc0_empty(vc0_empty),
    .vc1_empty(vc1_empty),
    .vc0_head(vc0_head),
    .vc1_head(vc1_head),
    .vc0_data(vc0_data),
    .vc1_data(vc1_data),
    .d0_almost_full(d0_almost_full),
    .d1_almost_full(d1_almost_full),
    .vc0_pop(vc0_pop),
    .vc1_pop(vc1_pop),
    .d0_push(d0_push),
    .d1_push(d1_push),
    .d0_data(d0_data),
    .d1_data(d1_data),
    .arb_idle(arb_idle)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit full_for(logic [W-1:0] h);
    return h[DB] ? d1_almost_full : d0_almost_full;
  endfunction

  always @(posedge clk) begin
    bit e0, e1;
    e0 = !vc0_empty && !full_for(vc0_head);
    e1 = !vc1_empty && !full_for(vc1_head);
    if (!reset || !init) begin
      m_init = 1'b1;
      m_age  = 0;
      m_fc   = 0;
    end else if (m_init) begin
      m_init = 1'b0;
    end else if (m_age != 0) begin
      m_age = (m_age == 1) ? 2 : 0;
    end else if (e1 && (!e0 || m_fc == WT)) begin
      m_win = 1'b1;
      m_dst = vc1_head[DB];
      m_fc  = 0;
      m_age = 1;
    end else if (e0) begin
      m_win = 1'b0;
      m_dst = vc0_head[DB];
      if (e1 && m_fc < WT) m_fc++;
      m_age = 1;
    end
  end

  always @(negedge clk) begin
    logic [W-1:0] w, x0, x1;
    w  = m_win ? vc1_data : vc0_data;
    x0 = (m_age == 2 && !m_dst) ? w : '0;
    x1 = (m_age == 2 && m_dst) ? w : '0;
    chk("vc0_pop", vc0_pop, 32'(m_age == 1 && !m_win));
    chk("vc1_pop", vc1_pop, 32'(m_age == 1 && m_win));
    chk("d0_push", d0_push, 32'(m_age == 2 && !m_dst));
    chk("d1_push", d1_push, 32'(m_age == 2 && m_dst));
    chk("d0_data", d0_data, 32'(x0));
    chk("d1_data", d1_data, 32'(x1));
    chk("arb_idle", arb_idle,
        32'(!m_init && m_age == 0 && vc0_empty && vc1_empty));
    if (vc0_pop) grant_log.push_back(0);
    if (vc1_pop) grant_log.push_back(1);
    if (vc0_pop || vc1_pop || d0_push || d1_push) xfers++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pair(string name);
    int ord[6];
    ord = '{0, 0, 0, 0, 1, 0};
    grant_log.delete();
    step();
    vc0_head = 6'h03; vc0_data = 6'h03; vc0_empty = 1'b0;
    vc1_head = 6'h0A; vc1_data = 6'h0A; vc1_empty = 1'b0;
    repeat (18) step();
    vc0_empty = 1'b1; vc1_empty = 1'b1;
    repeat (4) step();
    chk({name, "_cnt"}, 32'(grant_log.size() >= 6), 32'd1);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      chk({name, "_ord"}, 32'(grant_log[i]), 32'(ord[i]));
  endtask

  initial begin
    logic [15:0] tbl[24];
    reset = 1'b0; init = 1'b1;
    vc0_empty = 1'b1; vc1_empty = 1'b1;
    vc0_head = '0; vc1_head = '0; vc0_data = '0; vc1_data = '0;
    d0_almost_full = 1'b0; d1_almost_full = 1'b0;

    // reset release, idle with nothing to do
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    xfers = 0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rst_idle", arb_idle, 1);
    chk("rst_xfers", xfers, 0);

    // single VC0 word to D1
    step();
    vc0_head = 6'h15; vc0_data = 6'h15; vc0_empty = 1'b0;
    step();
    vc0_empty = 1'b1;
    @(negedge clk);
    chk("w15_pop", vc0_pop, 1);
    @(negedge clk);
    chk("w15_push1", d1_push, 1);
    chk("w15_data1", d1_data, 6'h15);
    chk("w15_push0", d0_push, 0);
    repeat (3) step();

    // weighted round: four VC0 then one VC1
    run_pair("wt");

    // VC0 blocked by D1 backpressure, VC1 to D0 goes first
    step();
    vc0_head = 6'h10; vc0_data = 6'h10; vc0_empty = 1'b0;
    vc1_head = 6'h05; vc1_data = 6'h05; vc1_empty = 1'b0;
    d1_almost_full = 1'b1;
    step();
    vc1_empty = 1'b1;
    @(negedge clk);
    chk("af_pop1", vc1_pop, 1);
    chk("af_pop0", vc0_pop, 0);
    @(negedge clk);
    chk("af_push0", d0_push, 1);
    chk("af_data0", d0_data, 6'h05);
    step();
    d1_almost_full = 1'b0;
    step();
    vc0_empty = 1'b1;
    @(negedge clk);
    chk("af_late0", vc0_pop, 1);
    @(negedge clk);
    chk("af_push1", d1_push, 1);
    chk("af_data1", d1_data, 6'h10);
    repeat (2) step();

    // build up fairness credit, then abort a transfer with reset
    vc0_head = 6'h03; vc0_empty = 1'b0;
    vc1_head = 6'h0A; vc1_empty = 1'b0;
    repeat (6) step();
    vc0_empty = 1'b1; vc1_empty = 1'b1;
    repeat (4) step();
    vc0_head = 6'h01; vc0_data = 6'h01; vc0_empty = 1'b0;
    step();
    vc0_empty = 1'b1; reset = 1'b0;
    @(negedge clk);
    chk("ab_pop", vc0_pop, 1);
    @(negedge clk);
    chk("ab_push0", d0_push, 0);
    chk("ab_push1", d1_push, 0);
    chk("ab_data0", d0_data, 0);
    chk("ab_idle", arb_idle, 0);
    step();
    reset = 1'b1;
    repeat (2) step();
    run_pair("fc_clr");

    // backpressure during POP does not cancel the transfer
    vc0_head = 6'h02; vc0_data = 6'h02; vc0_empty = 1'b0;
    step();
    vc0_empty = 1'b1; d0_almost_full = 1'b1;
    @(negedge clk);
    chk("bp_pop", vc0_pop, 1);
    @(negedge clk);
    chk("bp_push", d0_push, 1);
    chk("bp_data", d0_data, 6'h02);
    step();
    d0_almost_full = 1'b0;
    repeat (2) step();

    // init=0 during PUSH: push completes, then INIT
    vc1_head = 6'h11; vc1_data = 6'h11; vc1_empty = 1'b0;
    step();
    vc1_empty = 1'b1;
    step();
    init = 1'b0;
    @(negedge clk);
    chk("in_push", d1_push, 1);
    @(negedge clk);
    chk("in_after", d1_push, 0);
    chk("in_idle", arb_idle, 0);
    step();
    init = 1'b1;
    repeat (2) step();

    // mixed vector table: {e0,e1,af0,af1,h0[5:0],h1[5:0]}
    tbl = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
            16'h0000, 16'h0000, 16'h0000, 16'h0000,
            16'h0000, 16'h0000, 16'h0000, 16'h0000,
            16'h1400, 16'h1400, 16'h1400, 16'h2400,
            16'h2400, 16'h2400, 16'h8000, 16'h8000,
            16'h8000, 16'h4011, 16'h4011, 16'h4011};
    for (int i = 0; i < 24; i++) begin
      vc0_empty      = tbl[i][15];
      vc1_empty      = tbl[i][14];
      d0_almost_full = tbl[i][13];
      d1_almost_full = tbl[i][12];
      vc0_head       = tbl[i][11:6];
      vc1_head       = tbl[i][5:0];
      vc0_data       = 6'(i);
      vc1_data       = 6'(i) | 6'h20;
      step();
    end
    vc0_empty = 1'b1; vc1_empty = 1'b1;
    d0_almost_full = 1'b0; d1_almost_full = 1'b0;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
